// File: rtl/adder_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : adder_sum_accumulator
//  Brief    : Batches the adder-stage sum stream into a wide running total and
//             presents total, beat count and sticky overflow on a valid/ready
//             output port. Batch length is latched on the first beat and a
//             flush input closes a batch early.
//  Option   : ADDER_ACC_SATURATE_EN - when defined the accumulator clamps to
//             all-ones on overflow instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_sum_accumulator #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int BATCH_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_sum,
    output logic               in_ready,
    input  logic [BATCH_W-1:0] batch_len,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [BATCH_W:0]   out_count,
    output logic               out_ovf
);

    localparam logic [BATCH_W:0] c_ONE = {{BATCH_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [BATCH_W:0]   r_count;
    logic [BATCH_W:0]   w_count_nxt;
    logic [BATCH_W:0]   r_len;
    logic [BATCH_W:0]   w_len_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;

    logic               w_beat;
    logic [BATCH_W:0]   w_len_in;
    logic [ACC_W-1:0]   w_in_ext;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_add;
    logic [BATCH_W:0]   w_count_inc;

    // Incoming sum zero-extended to the accumulator width.
    generate
        if (ACC_W > DATA_W) begin : g_ext_pad
            assign w_in_ext = {{(ACC_W-DATA_W){1'b0}}, in_sum};
        end else begin : g_ext_none
            assign w_in_ext = in_sum;
        end
    endgenerate

    // A requested length of zero behaves as a single-sum batch.
    assign w_len_in    = (batch_len == '0) ? c_ONE : {1'b0, batch_len};
    assign in_ready    = !rst && (r_state != S_OUT);
    assign w_beat      = in_valid && in_ready;
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_in_ext};
    assign w_count_inc = r_count + c_ONE;

    // Once the carry fires in saturating mode the total sits at all-ones;
    // further additions of non-zero sums carry again, so it stays clamped.
`ifdef ADDER_ACC_SATURATE_EN
    assign w_acc_add = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_add = w_sum[ACC_W-1:0];
`endif

    // Next-state and datapath update for the batch controller.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_len_nxt   = r_len;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    w_len_nxt   = w_len_in;
                    w_acc_nxt   = w_in_ext;
                    w_count_nxt = c_ONE;
                    w_ovf_nxt   = 1'b0;
                    if ((w_len_in == c_ONE) || flush) begin
                        w_state_nxt = S_OUT;
                    end else begin
                        w_state_nxt = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (w_beat) begin
                    w_acc_nxt   = w_acc_add;
                    w_count_nxt = w_count_inc;
                    if (w_sum[ACC_W]) begin
                        w_ovf_nxt = 1'b1;
                    end
                    if ((w_count_inc == r_len) || flush) begin
                        w_state_nxt = S_OUT;
                    end
                end else if (flush) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_len   <= c_ONE;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_len   <= w_len_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign out_valid = (r_state == S_OUT);
    assign out_acc   = r_acc;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: doc/adder_sum_accumulator.md
# adder_sum_accumulator

Downstream consumer of the adder stage. Takes the registered sum `c` one value per accepted beat and adds it into a wide running total over a programmable batch. It then presents the batch total, beat count and an overflow flag on a valid/ready output port. The block gives the verification environment and later datapath stages a batched, backpressure-aware view of the adder's results.

## Interface
- `DATA_W`, 8, width of each incoming sum (matches the adder `c` width)
- `ACC_W`, 16, accumulator width; must be ≥ `DATA_W`
- `BATCH_W`, 4, width of the batch-length control

- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  `in_sum` holds a valid sum
- `in_sum`  in  `DATA_W`  sum from adder stage
- `in_ready`  out  1  block accepts `in_sum` this cycle
- `batch_len`  in  `BATCH_W`  sums per batch; 0 is treated as 1
- `flush`  in  1  close current batch early
- `out_valid`  out  1  batch result available
- `out_ready`  in  1  consumer takes result
- `out_acc`  out  `ACC_W`  batch total
- `out_count`  out  `BATCH_W`+1  number of sums in batch
- `out_ovf`  out  1  sticky: accumulation overflowed during batch

## Operation
- Beat accepted when `in_valid && in_ready`.
- FSM states:
  - IDLE: `in_ready`=1. First accepted beat latches `batch_len`, loads acc=`in_sum` and count=1, then goes to ACCUM. If the latched length is 1, it goes straight to OUT instead.
  - ACCUM: `in_ready`=1. Each accepted beat does acc += zero-extended `in_sum` and count += 1. When count reaches the latched length, go to OUT. Changes to `batch_len` are ignored while in ACCUM.
  - OUT: `in_ready`=0, `out_valid`=1. On `out_ready`, go to IDLE and clear acc, count and ovf.
- `flush`:
  - In ACCUM, `flush` closes the batch and moves to OUT.
  - If a beat is accepted in the same cycle as `flush`, that beat is included before closing.
  - In IDLE, `flush` with no beat is ignored.
  - In IDLE, `flush` together with a beat produces a 1-sum batch.
  - In OUT, `flush` is ignored.
- Arithmetic:
  - Sum computed in `ACC_W`+1 bits.
  - A carry out of bit `ACC_W`-1 sets `ovf`, which stays set until the batch is consumed.
  - Default behaviour wraps modulo 2^`ACC_W`.
- `out_acc`, `out_count` and `out_ovf` are driven from registers and held stable while `out_valid`=1 and `out_ready`=0.
- While `rst` is asserted, `in_ready`=0.

## Timing
- Reset values (cycle after `rst` sampled high): state IDLE, `out_valid`=0, `out_acc`=0, `out_count`=0, `out_ovf`=0. `in_ready`=1 once `rst` deasserts.
- Reset mid-batch discards the partial total with no output.
- `out_valid` rises in the cycle after the closing beat or `flush` is accepted.
- Handshake cycle (`out_valid && out_ready`): `out_valid`=0 and `in_ready`=1 in the next cycle.
- There is exactly one bubble between batches; no beat is accepted during OUT.
- Throughput: one sum per cycle within a batch.

## Configuration
- `ADDER_ACC_SATURATE_EN`:
  - Defined: on overflow, the accumulator clamps to 2^`ACC_W`−1 and stays there for the rest of the batch. `out_ovf` is still set.
  - Undefined: wrap modulo 2^`ACC_W`.

## Test plan
- `batch_len`=4, sums 10, 20, 30, 40 back-to-back, `out_ready`=1 → one cycle after the 4th beat: `out_valid`=1, `out_acc`=100, `out_count`=4, `out_ovf`=0. `in_ready`=1 the cycle after the handshake.
- `ACC_W`=9, `batch_len`=3, sums 255, 255, 255 → `out_acc`=253, `out_ovf`=1. With `ADDER_ACC_SATURATE_EN`: `out_acc`=511, `out_ovf`=1.
- Batch closes with `out_ready`=0 for 5 cycles while `in_valid`=1 → outputs stable, `in_ready`=0, no beat consumed. On `out_ready`=1 the result is taken, and the next batch starts from the held input.
- `batch_len`=8, sums 5, 7 then `flush` → `out_acc`=12, `out_count`=2. `flush` in IDLE with `in_valid`=0 → no output.
- `rst` asserted after 2 of 4 beats → next cycle all outputs 0. A new batch 3, 4, 5, 6 gives `out_acc`=18, `out_count`=4.
- `batch_len`=0, sum 9 → `out_acc`=9, `out_count`=1 one cycle later.
